// File: rtl/data_memory_lsu.sv
// Word-organised data memory with an RV32I load/store front end: byte/half/word
// access, sign/zero extension, error detection and a wait-state request handshake.
module data_memory_lsu #(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             we_q;
    logic [2:0]       f3_q;
    logic [AW+1:0]    addr_q;
    logic [31:0]      wdata_q;

    logic             err_q;
    logic             rzero_q;
    logic [2:0]       rf3_q;
    logic [1:0]       roff_q;

    logic             f3_bad;
    logic             req_err;
    logic             accept;
    logic             wr_en;
    logic             rd_en;
    logic [AW-1:0]    widx;
    logic [31:0]      rd_word;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      ext_data;

    // Range is judged on the full address at acceptance, so only the in-range bits are kept.
    always_comb begin
        f3_bad  = req_we ? (req_funct3 > 3'd2)
                         : ((req_funct3 == 3'd3) || (req_funct3 > 3'd5));
        req_err = f3_bad
               || ((req_funct3[1:0] == 2'd1) && req_addr[0])
               || ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00))
               || ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
    end

    assign accept = (state_q == S_IDLE) && req_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        state_d = S_RESP;
                    end else if (WAIT_CYCLES == 0) begin
                        state_d = S_ACCESS;
                    end else begin
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ACCESS: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rzero_q <= 1'b1;
            rf3_q   <= '0;
            roff_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr[AW+1:0];
                wdata_q <= req_wdata;
            end
            // Response fields change only on entry to RESP.
            if (accept && req_err) begin
                err_q   <= 1'b1;
                rzero_q <= 1'b1;
            end
            if (state_q == S_ACCESS) begin
                err_q   <= 1'b0;
                rzero_q <= we_q;
                rf3_q   <= f3_q;
                roff_q  <= addr_q[1:0];
            end
        end
    end

    assign widx  = addr_q[AW+1:2];
    assign wr_en = (state_q == S_ACCESS) && we_q;
    assign rd_en = (state_q == S_ACCESS) && !we_q;

    // One byte-wide RAM per lane gives independent byte write enables.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] rd_q;
            logic       sel;
            logic [7:0] wd;

            always_comb begin
                case (f3_q[1:0])
                    2'd0: begin
                        sel = (addr_q[1:0] == LANE);
                        wd  = wdata_q[7:0];
                    end
                    2'd1: begin
                        sel = (addr_q[1] == LANE[1]);
                        wd  = wdata_q[8*(gi%2) +: 8];
                    end
                    default: begin
                        sel = 1'b1;
                        wd  = wdata_q[8*gi +: 8];
                    end
                endcase
            end

            always_ff @(posedge clk) begin
                if (wr_en && sel) begin
                    mem[widx] <= wd;
                end
                if (rd_en) begin
                    rd_q <= mem[widx];
                end
            end

            assign rd_word[8*gi +: 8] = rd_q;
        end
    endgenerate

    always_comb begin
        byte_sel = 8'(rd_word >> {roff_q, 3'b000});
        half_sel = 16'(rd_word >> {roff_q[1], 4'b0000});
        case (rf3_q)
            3'd0:    ext_data = {{24{byte_sel[7]}}, byte_sel};
            3'd4:    ext_data = {24'h0, byte_sel};
            3'd1:    ext_data = {{16{half_sel[15]}}, half_sel};
            3'd5:    ext_data = {16'h0, half_sel};
            default: ext_data = rd_word;
        endcase
    end

    assign rsp_rdata = rzero_q ? 32'h0 : ext_data;
    assign rsp_err   = err_q;
    assign rsp_valid = (state_q == S_RESP);
    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_memory_lsu.sv
// Self-checking bench for data_memory_lsu: a byte-addressed little-endian model
// predicts load data, errors, latency and handshake timing.
module tb_data_memory_lsu;

    localparam int DEPTH = 64;
    localparam int W     = 1;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    always #5 clk = ~clk;

    data_memory_lsu #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_CYCLES(W),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .srst(srst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_funct3(req_funct3),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .busy(busy)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [7:0] ref_mem [DEPTH*4];

    bit          mon_en = 1'b0;
    logic [31:0] rsp_q [$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mon_en && rsp_valid) rsp_q.push_back(rsp_rdata);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        bit bad;
        if (we) bad = !(f3 inside {3'd0, 3'd1, 3'd2});
        else    bad = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (f3 inside {3'd1, 3'd5} && (a % 2 != 0)) bad = 1'b1;
        if (f3 == 3'd2 && (a % 4 != 0)) bad = 1'b1;
        if ((a / 4) >= DEPTH) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int b;
        logic [31:0] v;
        b = int'(a);
        case (f3)
            3'd0: v = {{24{ref_mem[b][7]}}, ref_mem[b]};
            3'd4: v = {24'h0, ref_mem[b]};
            3'd1: v = {{16{ref_mem[b+1][7]}}, ref_mem[b+1], ref_mem[b]};
            3'd5: v = {16'h0, ref_mem[b+1], ref_mem[b]};
            default: v = {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
        endcase
        return v;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = 1 << f3[1:0];
        for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
    endtask

    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
        bit          e;
        logic [31:0] exp_rd;
        int          exp_lat, lat, busy_n, n;
        e       = model_err(we, f3, a);
        exp_rd  = (e || we) ? 32'h0 : model_load(f3, a);
        exp_lat = e ? 0 : W + 1;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        lat = 0; busy_n = 0;
        while (lat < 100) begin
            @(negedge clk);
            if (busy && !req_ready) busy_n++;
            if (rsp_valid) break;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " err"}, 32'(rsp_err), 32'(e));
        chk({tag, " rdata"}, rsp_rdata, exp_rd);
        chk({tag, " busy cycles"}, 32'(busy_n), 32'(exp_lat + 1));
        rd = rsp_rdata;
        @(negedge clk);
        chk({tag, " pulse width"}, 32'(rsp_valid), 32'd0);
        chk({tag, " ready after"}, 32'(req_ready), 32'd1);
        chk({tag, " rdata hold"}, rsp_rdata, exp_rd);
        if (!e && we) model_store(f3, a, wd);
        $display("txn %-12s we=%0d f3=%0d addr=0x%08h wdata=0x%08h -> err=%0d rdata=0x%08h lat=%0d",
                 tag, we, f3, a, wd, e, rd, lat);
    endtask

    initial begin
        logic [31:0] rd, prior;
        int acc_cyc [3];
        logic [31:0] b2b_addr [3];
        logic [31:0] exp_q [$];
        int n, hits;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rdata", rsp_rdata, 32'h0);
        chk("rst err", 32'(rsp_err), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        srst = 1'b0;
        @(negedge clk);
        chk("rst ready", 32'(req_ready), 32'd1);

        // Give every word known contents
        for (int i = 0; i < DEPTH; i++) do_req("init", 1'b1, 3'd2, 32'(i * 4), $urandom, rd);

        // Directed
        do_req("sw10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd);
        do_req("lw10", 1'b0, 3'd2, 32'h10, 32'h0, rd);
        chk("lw10 const", rd, 32'hDEADBEEF);
        do_req("sb11", 1'b1, 3'd0, 32'h11, 32'h0000005A, rd);
        do_req("lw10b", 1'b0, 3'd2, 32'h10, 32'h0, rd);
        chk("sb merge const", rd, 32'hDEAD5AEF);
        do_req("sh12", 1'b1, 3'd1, 32'h12, 32'h00008001, rd);
        do_req("lw10c", 1'b0, 3'd2, 32'h10, 32'h0, rd);
        chk("sh merge const", rd, 32'h80015AEF);
        do_req("lb13", 1'b0, 3'd0, 32'h13, 32'h0, rd);
        chk("lb const", rd, 32'hFFFFFF80);
        do_req("lbu13", 1'b0, 3'd4, 32'h13, 32'h0, rd);
        chk("lbu const", rd, 32'h00000080);
        do_req("lh12", 1'b0, 3'd1, 32'h12, 32'h0, rd);
        chk("lh const", rd, 32'hFFFF8001);
        do_req("lhu12", 1'b0, 3'd5, 32'h12, 32'h0, rd);
        chk("lhu const", rd, 32'h00008001);

        // Error cases, memory word must survive
        do_req("err lw12", 1'b0, 3'd2, 32'h12, 32'h0, rd);
        do_req("err sh11", 1'b1, 3'd1, 32'h11, 32'hFFFFFFFF, rd);
        do_req("err f3_011", 1'b1, 3'd3, 32'h10, 32'hFFFFFFFF, rd);
        do_req("err range", 1'b1, 3'd2, 32'(4 * DEPTH), 32'hFFFFFFFF, rd);
        do_req("lw10d", 1'b0, 3'd2, 32'h10, 32'h0, rd);
        chk("after errors const", rd, 32'h80015AEF);

        // Reset during WAIT discards the store
        prior = model_load(3'd2, 32'h20);
        do_req("lw20", 1'b0, 3'd2, 32'h20, 32'h0, rd);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'h12345678;
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("midrst in wait", 32'(busy), 32'd1);
        srst = 1'b1;
        #1;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst ready", 32'(req_ready), 32'd1);
        chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst rdata", rsp_rdata, 32'h0);
        chk("midrst err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        srst = 1'b0;
        hits = 0;
        repeat (6) begin @(negedge clk); if (rsp_valid) hits++; end
        chk("midrst no rsp", 32'(hits), 32'd0);
        do_req("lw20 after", 1'b0, 3'd2, 32'h20, 32'h0, rd);
        chk("midrst prior kept", rd, prior);

        // Back-to-back loads with req_valid held high
        for (int k = 0; k < 3; k++) b2b_addr[k] = 32'($urandom_range(0, DEPTH - 1) * 4);
        rsp_q.delete();
        mon_en = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = b2b_addr[0];
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!req_ready && n < 100) begin @(negedge clk); n++; end
            @(posedge clk);
            #1;
            acc_cyc[k] = cyc;
            exp_q.push_back(model_load(3'd2, b2b_addr[k]));
            if (k < 2) req_addr = b2b_addr[k+1];
            else req_valid = 1'b0;
        end
        repeat (3 * (W + 3) + 4) @(negedge clk);
        mon_en = 1'b0;
        chk("b2b spacing 0-1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(W + 3));
        chk("b2b spacing 1-2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(W + 3));
        chk("b2b rsp count", 32'(rsp_q.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (rsp_q.size() > k) chk($sformatf("b2b rsp %0d", k), rsp_q[k], exp_q[k]);
            else chk($sformatf("b2b rsp %0d missing", k), 32'd1, 32'd0);
        end

        // Randomized mix, including illegal funct3, misalignment and out-of-range
        for (int t = 0; t < 200; t++) begin
            int idx;
            logic [31:0] a;
            idx = ($urandom_range(0, 7) == 0) ? DEPTH + int'($urandom_range(0, 200))
                                              : int'($urandom_range(0, DEPTH - 1));
            a = 32'(idx * 4 + int'($urandom_range(0, 3)));
            do_req("rand", 1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
